// File: rtl/dlx_pkg.sv
// Shared DLX definitions: format codes, opcode/function constants used by the
// control decoder and the program encoder, field widths, encoder states.
package dlx_pkg;

  // Instruction format selector presented with each field bundle
  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_J   = 2'b10,
    FMT_BAD = 2'b11
  } fmt_e;

  // Field widths; DLX numbers bits from the MSB, so DLX bit 0 is [W-1] here
  localparam int WORD_W  = 32;
  localparam int OP_W    = 6;
  localparam int FN_W    = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int IMM_I_W = 16;
  localparam int IMM_J_W = 26;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQZ  = 6'h04;
  localparam logic [OP_W-1:0] OP_BNEZ  = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SUBI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [FN_W-1:0] FN_ADD = 6'h20;
  localparam logic [FN_W-1:0] FN_SUB = 6'h22;
  localparam logic [FN_W-1:0] FN_AND = 6'h24;
  localparam logic [FN_W-1:0] FN_OR  = 6'h25;
  localparam logic [FN_W-1:0] FN_XOR = 6'h26;
  localparam logic [FN_W-1:0] FN_SLT = 6'h2A;

  // Program loader states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } enc_state_e;

  // True when a 26-bit immediate field carries a value that fits the 16-bit
  // I-type immediate: upper bits all zero or a sign extension of bit 15.
  function automatic logic imm_fits_i(input logic [IMM_J_W-1:0] imm);
    return (imm[IMM_J_W-1:IMM_I_W] == '0) ||
           (imm[IMM_J_W-1:IMM_I_W] == {(IMM_J_W-IMM_I_W){imm[IMM_I_W-1]}});
  endfunction

endpackage

// File: rtl/dlx_skid_buf.sv
// Two-entry valid/ready buffer between the encoder and the instruction memory
// write port. Output comes straight from storage registers, and in_ready is a
// function of the fill level only, so nothing on the input side depends on
// out_ready combinationally.
module dlx_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   level
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign in_ready  = (level != 2'd2);
  assign out_valid = (level != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage, pointers and fill level; simultaneous push/pop keeps 1 word/cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the two data entries are reset too, so the write-data port reads
      // zero after reset instead of stale contents; cheap at this depth.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this block
      // sees the pre-edge value regardless of statement order.
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      level <= level + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/dlx_inst_encoder.sv
// DLX program loader: packs instruction field bundles into 32-bit words and
// writes them to instruction memory at incrementing word addresses.
// Optional build macro DLX_ENC_RANGE_CHECK_EN: reject I-type immediates that do
// not fit 16 bits and non-zero register fields the format does not use.
// DLX numbers bits from the MSB; ports here are [W-1:0], so DLX Imm[10:25] is
// Imm[15:0] and DLX OpCode[0] is OpCode[5].
module dlx_inst_encoder
  import dlx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  localparam int         CNT_W     = $clog2(MAX_WORDS) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic               Finish,
  input  logic               InValid,
  output logic               InReady,
  input  logic [1:0]         Format,
  input  logic [OP_W-1:0]    OpCode,
  input  logic [FN_W-1:0]    Function,
  input  logic [REG_W-1:0]   Rs1,
  input  logic [REG_W-1:0]   Rs2,
  input  logic [REG_W-1:0]   Rd,
  input  logic [IMM_J_W-1:0] Imm,
  output logic               IMemWE,
  input  logic               IMemReady,
  output logic [31:0]        IMemAddr,
  output logic [WORD_W-1:0]  IMemData,
  output logic [CNT_W-1:0]   Count,
  output logic               Busy,
  output logic               Done,
  output logic               Full,
  output logic               Error
);

  localparam int               OCC_W   = CNT_W + 1;
  localparam logic [OCC_W-1:0] MAX_OCC = OCC_W'(MAX_WORDS);

  fmt_e              fmt;
  enc_state_e        state;
  logic [WORD_W-1:0] enc_word;
  logic              word_ok;
  logic              range_ok;
  logic              accept;
  logic              push;
  logic              wr_done;
  logic              start_ok;
  logic              skid_in_ready;
  logic [1:0]        skid_level;
  logic [OCC_W-1:0]  occupancy;

  assign fmt       = fmt_e'(Format);
  // Words already written plus words waiting in the buffer; never exceeds MAX_WORDS
  assign occupancy = OCC_W'(Count) + OCC_W'(skid_level);
  assign Full      = (occupancy >= MAX_OCC);
  assign InReady   = (state == ST_LOAD) & skid_in_ready & ~Full;
  assign accept    = InValid & InReady;
  assign push      = accept & word_ok;
  assign wr_done   = IMemWE & IMemReady;
  assign start_ok  = Start & ((state == ST_IDLE) | (state == ST_DONE));

`ifdef DLX_ENC_RANGE_CHECK_EN
  // Reject oversize I-type immediates and register fields the format leaves unused
  always_comb begin
    range_ok = 1'b1;
    case (fmt)
      FMT_I:   range_ok = imm_fits_i(Imm) && (Rs2 == '0);
      FMT_J:   range_ok = (Rs1 == '0) && (Rs2 == '0) && (Rd == '0);
      default: range_ok = 1'b1;
    endcase
  end
`else
  // No field checking: upper I-type immediate bits and unused fields are dropped
  assign range_ok = 1'b1;
`endif

  // Pack the bundle into a DLX word and decide whether it may be written
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch forms.
    enc_word = '0;
    word_ok  = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_word = {OpCode, Rs1, Rs2, Rd, {SHAMT_W{1'b0}}, Function};
        word_ok  = range_ok;
      end
      FMT_I: begin
        enc_word = {OpCode, Rs1, Rd, Imm[IMM_I_W-1:0]};
        word_ok  = range_ok;
      end
      FMT_J: begin
        enc_word = {OpCode, Imm};
        word_ok  = range_ok;
      end
      default: begin
        enc_word = '0;
        word_ok  = 1'b0;
      end
    endcase
  end

  dlx_skid_buf #(
    .W (WORD_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (skid_in_ready),
    .in_data   (enc_word),
    .out_valid (IMemWE),
    .out_ready (IMemReady),
    .out_data  (IMemData),
    .level     (skid_level)
  );

  // Loader FSM with registered Busy/Done and sticky Error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            state <= ST_LOAD;
            Busy  <= 1'b1;
            Done  <= 1'b0;
            Error <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept && !word_ok) begin
            Error <= 1'b1;
          end
          if (Finish) begin
            if ((skid_level == 2'd0) && !push) begin
              state <= ST_DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (skid_level == 2'd0) begin
            state <= ST_DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

  // Write address and word count advance only when memory takes a word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IMemAddr <= BASE_ADDR;
      Count    <= '0;
    end else if (start_ok) begin
      IMemAddr <= BASE_ADDR;
      Count    <= '0;
    end else if (wr_done) begin
      IMemAddr <= IMemAddr + 32'd4;
      Count    <= Count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dlx_inst_encoder.sv
// Directed bench for dlx_inst_encoder: a default-size instance plus a
// MAX_WORDS=4 instance sharing the same stimulus.
module tb_dlx_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start, Finish, InValid;
  logic [1:0]  Format;
  logic [5:0]  OpCode, Function;
  logic [4:0]  Rs1, Rs2, Rd;
  logic [25:0] Imm;
  logic        IMemReady = 1'b1;

  logic        InReady, IMemWE, Busy, Done, Full, Error;
  logic [31:0] IMemAddr, IMemData;
  logic [10:0] Count;

  logic        s_inready, s_we, s_busy, s_done, s_full, s_error;
  logic [31:0] s_addr, s_data;
  logic [2:0]  s_count;

  int          total = 0;
  int          bad   = 0;
  int          rdy_mode = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  dlx_inst_encoder dut (
    .clk(clk), .rst(rst), .Start(Start), .Finish(Finish), .InValid(InValid),
    .InReady(InReady), .Format(Format), .OpCode(OpCode), .Function(Function),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Imm(Imm), .IMemWE(IMemWE),
    .IMemReady(IMemReady), .IMemAddr(IMemAddr), .IMemData(IMemData),
    .Count(Count), .Busy(Busy), .Done(Done), .Full(Full), .Error(Error)
  );

  dlx_inst_encoder #(.MAX_WORDS(4)) dut_small (
    .clk(clk), .rst(rst), .Start(Start), .Finish(Finish), .InValid(InValid),
    .InReady(s_inready), .Format(Format), .OpCode(OpCode), .Function(Function),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Imm(Imm), .IMemWE(s_we),
    .IMemReady(IMemReady), .IMemAddr(s_addr), .IMemData(s_data),
    .Count(s_count), .Busy(s_busy), .Done(s_done), .Full(s_full), .Error(s_error)
  );

  always #5 clk = ~clk;

  // Memory-side ready pattern: 0 = always ready, 1 = toggling, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       IMemReady = ~IMemReady;
      2:       IMemReady = 1'b0;
      default: IMemReady = 1'b1;
    endcase
  end

  // Record every completed write of the default-size instance
  always @(negedge clk) begin
    if (!rst && IMemWE && IMemReady) begin
      wq_addr.push_back(IMemAddr);
      wq_data.push_back(IMemData);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic pulse_finish();
    Finish = 1'b1;
    tick();
    Finish = 1'b0;
  endtask

  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic [25:0] im);
    logic got = 1'b0;
    Format = f; OpCode = op; Function = fn; Rs1 = r1; Rs2 = r2; Rd = rd; Imm = im;
    InValid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      got = InReady;
      tick();
      if (got) break;
    end
    InValid = 1'b0;
    check("send_accepted", got, 1);
  endtask

  task automatic wait_writes(input int n);
    int cyc = 0;
    while (wq_data.size() < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("writes_reached_%0d", n), wq_data.size() >= n, 1);
    tick();
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!(Done && s_done) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("done_reached", Done & s_done, 1);
    tick();
  endtask

  initial begin
    Start = 0; Finish = 0; InValid = 0; Format = 0; OpCode = 0; Function = 0;
    Rs1 = 0; Rs2 = 0; Rd = 0; Imm = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_inready", InReady, 0);
    check("rst_we", IMemWE, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_full", Full, 0);
    check("rst_error", Error, 0);
    check("rst_addr", IMemAddr, 32'h0);
    check("rst_data", IMemData, 32'h0);
    check("rst_count", Count, 0);
    tick();
    rst = 1'b0;
    tick();

    // Start, then R-type ADD r3=r1+r2
    pulse_start();
    @(negedge clk);
    check("start_busy", Busy, 1);
    check("start_inready", InReady, 1);
    check("start_error", Error, 0);
    tick();
    send(2'b00, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 26'h0);
    @(negedge clk);
    check("add_we", IMemWE, 1);
    check("add_data", IMemData, 32'h0022_1820);
    check("add_addr", IMemAddr, 32'h0);
    tick();
    @(negedge clk);
    check("add_count", Count, 1);
    check("add_next_addr", IMemAddr, 32'h4);
    tick();

    // I-type ADDI r5=r4+(-1) and J-type JAL 0x10, back to back
    send(2'b01, 6'h08, 6'h00, 5'd4, 5'd0, 5'd5, 26'h000_FFFF);
    send(2'b10, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 26'h000_0010);
    wait_writes(3);
    check("addi_data", wq_data[1], 32'h2085_FFFF);
    check("addi_addr", wq_addr[1], 32'h4);
    check("jal_data", wq_data[2], 32'h0C00_0010);
    check("jal_addr", wq_addr[2], 32'h8);
    @(negedge clk);
    check("three_count", Count, 3);
    tick();
    pulse_finish();
    wait_done();
    @(negedge clk);
    check("done_busy", Busy, 0);
    check("done_inready", InReady, 0);
    check("done_count", Count, 3);
    tick();

    // 8-word stream with memory ready toggling
    pulse_start();
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      send(2'b10, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 26'h100 + 26'(i));
    wait_writes(8);
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stream_data_%0d", i), wq_data[i], 32'h0C00_0100 + 32'(i));
      check($sformatf("stream_addr_%0d", i), wq_addr[i], 32'(i * 4));
    end

    // Illegal format mid-stream, then the next word lands at the next address
    send(2'b11, 6'h3F, 6'h3F, 5'd31, 5'd31, 5'd31, 26'h3FF_FFFF);
    @(negedge clk);
    check("bad_fmt_error", Error, 1);
    tick();
    send(2'b10, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 26'h55);
    wait_writes(9);
    check("after_bad_data", wq_data[8], 32'h0C00_0055);
    check("after_bad_addr", wq_addr[8], 32'h20);
    repeat (3) @(negedge clk);
    check("after_bad_nwrites", wq_data.size(), 9);
    check("after_bad_count", Count, 9);
    tick();
    pulse_finish();
    wait_done();
    @(negedge clk);
    check("error_sticky", Error, 1);
    tick();

    // Oversize I-type immediate
    pulse_start();
    @(negedge clk);
    check("start_clears_error", Error, 0);
    tick();
    send(2'b01, 6'h08, 6'h00, 5'd1, 5'd0, 5'd2, 26'h001_0000);
`ifdef DLX_ENC_RANGE_CHECK_EN
    repeat (3) @(negedge clk);
    check("range_error", Error, 1);
    check("range_nwrites", wq_data.size(), 0);
    check("range_count", Count, 0);
    tick();
`else
    wait_writes(1);
    check("trunc_data", wq_data[0], 32'h2022_0000);
    check("trunc_error", Error, 0);
`endif
    pulse_finish();
    wait_done();

    // Full on the MAX_WORDS=4 instance: six offered, four taken
    pulse_start();
    for (int i = 0; i < 6; i++)
      send(2'b10, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 26'h200 + 26'(i));
    wait_writes(6);
    @(negedge clk);
    check("small_count", s_count, 4);
    check("small_full", s_full, 1);
    check("small_inready", s_inready, 0);
    check("small_busy", s_busy, 1);
    check("big_full", Full, 0);
    check("big_count", Count, 6);
    tick();
    pulse_finish();
    wait_done();
    @(negedge clk);
    check("small_done", s_done, 1);
    check("small_final_count", s_count, 4);
    tick();

    // Async reset while a write is stalled
    rdy_mode = 2;
    pulse_start();
    tick();
    send(2'b10, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 26'h66);
    @(negedge clk);
    check("stall_we", IMemWE, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_we", IMemWE, 0);
    check("async_rst_busy", Busy, 0);
    check("async_rst_data", IMemData, 32'h0);
    tick();
    rst = 1'b0;
    rdy_mode = 0;
    tick();
    tick();
    pulse_start();
    send(2'b10, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 26'h77);
    wait_writes(1);
    check("post_rst_addr", wq_addr[0], 32'h0);
    check("post_rst_data", wq_data[0], 32'h0C00_0077);
    @(negedge clk);
    check("post_rst_count", Count, 1);
    tick();

    // Finish with an empty buffer reaches DONE on the next cycle
    pulse_finish();
    @(negedge clk);
    check("finish_empty_done", Done, 1);
    check("finish_empty_busy", Busy, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
